// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game engine.
// State codes, LFSR constants, one-hot decode and the LFSR step function.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADD      = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_GAP = 3'd3,
        INPUT    = 3'd4,
        WIN      = 3'd5,
        FAIL     = 3'd6
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] onehot(input logic [2:0] v);
        return 8'h01 << v;
    endfunction

    // 8-bit Galois step: shift right, fold taps back in when the lsb falls out
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/simon_game_core_if.sv
// Pin-side bundle of the Simon engine: pacing/start/buttons in, LEDs and debug out.
// master drives the stimulus side, slave is the game core.
interface simon_game_core_if #(
    parameter int NUM_BTN = 4,
    parameter int MAX_LEN = 16
);
    localparam int IDX_W = $clog2(NUM_BTN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               tick;
    logic               start;
    logic [NUM_BTN-1:0] btn;
    logic [NUM_BTN-1:0] led;
    logic               error_led;
    logic               win_led;
    logic [LEN_W-1:0]   round_len;
    logic [IDX_W-1:0]   cur_val;
    logic [2:0]         state;

    modport master (
        output tick, start, btn,
        input  led, error_led, win_led, round_len, cur_val, state
    );

    modport slave (
        input  tick, start, btn,
        output led, error_led, win_led, round_len, cur_val, state
    );

endinterface

// File: rtl/simon_btn_edge.sv
// Button front end: 2-flop synchroniser, rising-edge detect, lowest-index priority.
// Simultaneous rises collapse to the lowest index; the rest are dropped.
module simon_btn_edge #(
    parameter int NUM_BTN = 4,
    parameter int IDX_W   = $clog2(NUM_BTN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    output logic               press_valid,
    output logic [IDX_W-1:0]   press_val,
    output logic [NUM_BTN-1:0] level
);

    logic [NUM_BTN-1:0] s1, s2, rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    assign rise        = s1 & ~s2;
    assign press_valid = |rise;
    assign level       = s2;

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        press_val = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) press_val = IDX_W'(i);
        end
    end

endmodule

// File: rtl/simon_game_core.sv
// Single-clock Simon engine paced by a 1-cycle tick; sequence grows one entry per round.
// Optional SIMON_INPUT_TIMEOUT_EN: fail if no press arrives within TIMEOUT_TICKS in INPUT.
module simon_game_core
    import simon_pkg::*;
#(
    parameter int NUM_BTN       = 4,
    parameter int MAX_LEN       = 16,
    parameter int SHOW_TICKS    = 2,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 8
) (
    input logic              clk,
    input logic              reset,
    simon_game_core_if.slave bus
);

    localparam int IDX_W    = $clog2(NUM_BTN);
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int ADDR_W   = $clog2(MAX_LEN);
    localparam int SG_MAX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TCNT_MAX = (SG_MAX > TIMEOUT_TICKS) ? SG_MAX : TIMEOUT_TICKS;
    localparam int TCNT_W   = $clog2(TCNT_MAX + 1);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                err_q, err_d;
    logic                win_q, win_d;
    logic [7:0]          lfsr_q;
    logic [IDX_W-1:0]    mem [MAX_LEN];
    logic [IDX_W-1:0]    cur_mem;
    logic                last_idx;

    logic                press_valid;
    logic [IDX_W-1:0]    press_val;
    logic [NUM_BTN-1:0]  level;
    logic [7:0]          oh;

    simon_btn_edge #(.NUM_BTN(NUM_BTN), .IDX_W(IDX_W)) u_btn (
        .clk        (clk),
        .reset      (reset),
        .btn        (bus.btn),
        .press_valid(press_valid),
        .press_val  (press_val),
        .level      (level)
    );

    assign cur_mem  = mem[idx_q[ADDR_W-1:0]];
    assign last_idx = (idx_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            win_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            win_q   <= win_d;
            lfsr_q  <= lfsr_next(lfsr_q);
        end
    end

    // Sequence RAM is deliberately unreset; only entries below round_len are ever read
    always_ff @(posedge clk) begin
        if (state_q == ADD) mem[len_q[ADDR_W-1:0]] <= lfsr_q[IDX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE, WIN, FAIL: begin
                if (bus.start) begin
                    len_d   = '0;
                    err_d   = 1'b0;
                    win_d   = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                tcnt_d  = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (bus.tick) begin
                    if (tcnt_q == TCNT_W'(SHOW_TICKS - 1)) begin
                        tcnt_d  = '0;
                        state_d = SHOW_GAP;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            SHOW_GAP: begin
                if (bus.tick) begin
                    if (tcnt_q == TCNT_W'(GAP_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = INPUT;
                        end else begin
                            idx_d   = idx_q + LEN_W'(1);
                            state_d = SHOW_ON;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
            end
            INPUT: begin
                // A press wins over a coincident tick, so the timeout restarts
                if (press_valid) begin
                    if (press_val == cur_mem) begin
                        if (!last_idx) begin
                            idx_d  = idx_q + LEN_W'(1);
                            tcnt_d = '0;
                        end else if (len_q != LEN_W'(MAX_LEN)) begin
                            state_d = ADD;
                        end else begin
                            win_d   = 1'b1;
                            state_d = WIN;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = FAIL;
                    end
                end
`ifdef SIMON_INPUT_TIMEOUT_EN
                else if (bus.tick) begin
                    if (tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
                        err_d   = 1'b1;
                        state_d = FAIL;
                    end else begin
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.led     = '0;
        bus.cur_val = '0;
        oh          = '0;
        unique case (state_q)
            SHOW_ON: begin
                bus.cur_val = cur_mem;
                oh          = onehot(3'(cur_mem));
                bus.led     = oh[NUM_BTN-1:0];
            end
            SHOW_GAP: bus.cur_val = cur_mem;
            INPUT: begin
                bus.cur_val = cur_mem;
                bus.led     = level;
            end
            WIN:     bus.led = '1;
            default: ;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.error_led = err_q;
    assign bus.win_led   = win_q;
    assign bus.round_len = len_q;

endmodule

// File: tb/tb_simon_game_core.sv
// Directed bench for simon_game_core; a shadow LFSR predicts each added sequence entry.
module tb_simon_game_core;
    import simon_pkg::*;

    localparam int NB = 4;
    localparam int ML = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    simon_game_core_if #(.NUM_BTN(NB), .MAX_LEN(ML)) sif ();

    simon_game_core #(
        .NUM_BTN(NB), .MAX_LEN(ML), .SHOW_TICKS(2), .GAP_TICKS(1), .TIMEOUT_TICKS(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (sif.slave)
    );

    always #5 clk = ~clk;

    wire [2:0] st = sif.state;

    // Tick generator: one-cycle pulse every 4 clocks while enabled
    initial begin
        int div;
        div = 0;
        sif.tick = 1'b0;
        forever begin
            @(negedge clk);
            div++;
            sif.tick = tick_en && (div % 4 == 0);
        end
    end

    // Shadow LFSR; the value present during an ADD cycle becomes the next entry
    logic [7:0] lfsr_m;
    logic [4:0] rl_m;
    logic [1:0] seq_m [ML];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_m <= 8'h01;
            rl_m   <= '0;
        end else begin
            lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
            if ((st == 3'd0 || st == 3'd5 || st == 3'd6) && sif.start) rl_m <= '0;
            else if (st == 3'd1) begin
                seq_m[rl_m[3:0]] <= lfsr_m[1:0];
                rl_m <= rl_m + 5'd1;
            end
        end
    end

    function automatic logic [3:0] oh4(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    task automatic wait_state(input logic [2:0] s, input int budget);
        int i;
        for (i = 0; i < budget && st != s; i++) begin
            @(negedge clk);
            #1;
        end
        n_total++;
        if (st != s) $display("FAIL wait_state: got state %0d, required %0d within %0d clks", st, s, budget);
        else n_pass++;
    endtask

    task automatic wait_input();
        tick_en = 1'b1;
        wait_state(3'd4, 600);
        tick_en = 1'b0;
    endtask

    task automatic press_pat(input logic [3:0] p);
        @(negedge clk);
        sif.btn = p;
        repeat (3) @(negedge clk);
        sif.btn = '0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic start_game();
        @(negedge clk);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int bad;
        sif.start = 1'b0;
        sif.btn   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (st != 0 || sif.led != 0 || sif.round_len != 0 || sif.error_led || sif.win_led) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL reset_hold: %0d bad cycles, required 0", bad); else n_pass++;
        n_total++; if (st !== 3'd0) $display("FAIL reset_state: got %0d, required 0", st); else n_pass++;
        n_total++; if (sif.led !== 4'h0) $display("FAIL reset_led: got %h, required 0", sif.led); else n_pass++;
        n_total++; if (sif.round_len !== 5'd0) $display("FAIL reset_len: got %0d, required 0", sif.round_len); else n_pass++;
        n_total++; if (sif.cur_val !== 2'd0) $display("FAIL reset_cur: got %0d, required 0", sif.cur_val); else n_pass++;
    endtask

    task automatic test_first_round();
        int on_t, gap_t, bad;
        start_game();
        n_total++; if (st !== 3'd1) $display("FAIL first_add: got %0d, required 1", st); else n_pass++;
        @(negedge clk);
        #1;
        n_total++; if (st !== 3'd2 || sif.cur_val !== seq_m[0]) $display("FAIL first_show: state %0d cur %0d, required 2/%0d", st, sif.cur_val, seq_m[0]); else n_pass++;
        on_t = 0; gap_t = 0; bad = 0;
        tick_en = 1'b1;
        for (int i = 0; i < 200 && st != 3'd4; i++) begin
            if (st == 3'd2) begin
                if (sif.tick) on_t++;
                if (sif.led !== oh4(seq_m[0])) bad++;
            end else if (st == 3'd3) begin
                if (sif.tick) gap_t++;
                if (sif.led !== 4'h0) bad++;
            end
            @(negedge clk);
            #1;
        end
        tick_en = 1'b0;
        n_total++; if (on_t !== 2) $display("FAIL show_ticks: got %0d, required 2", on_t); else n_pass++;
        n_total++; if (gap_t !== 1) $display("FAIL gap_ticks: got %0d, required 1", gap_t); else n_pass++;
        n_total++; if (bad !== 0) $display("FAIL show_led: %0d bad cycles, required 0", bad); else n_pass++;
        n_total++; if (st !== 3'd4 || sif.round_len !== 5'd1) $display("FAIL first_input: state %0d len %0d, required 4/1", st, sif.round_len); else n_pass++;
    endtask

    task automatic test_win();
        for (int r = 1; r <= ML; r++) begin
            for (int k = 0; k < r; k++) press_pat(oh4(seq_m[k]));
            if (r < ML) begin
                wait_input();
                n_total++; if (sif.round_len !== 5'(r + 1)) $display("FAIL win_round_len: got %0d, required %0d", sif.round_len, r + 1); else n_pass++;
            end
        end
        repeat (20) @(negedge clk);
        #1;
        n_total++; if (st !== 3'd5) $display("FAIL win_state: got %0d, required 5", st); else n_pass++;
        n_total++; if (sif.win_led !== 1'b1) $display("FAIL win_led: got %b, required 1", sif.win_led); else n_pass++;
        n_total++; if (sif.led !== 4'hF) $display("FAIL win_leds: got %h, required f", sif.led); else n_pass++;
        n_total++; if (sif.round_len !== 5'd16) $display("FAIL win_len: got %0d, required 16", sif.round_len); else n_pass++;
    endtask

    task automatic test_fail();
        start_game();
        n_total++; if (st !== 3'd1 || sif.win_led !== 1'b0 || sif.round_len !== 5'd0) $display("FAIL restart: state %0d win %b len %0d, required 1/0/0", st, sif.win_led, sif.round_len); else n_pass++;
        wait_input();
        press_pat(oh4(seq_m[0]));
        wait_input();
        press_pat(oh4(seq_m[0]));
        press_pat(oh4(seq_m[1]));
        // Round 3 is now parked in SHOW_ON because ticks are off
        press_pat(oh4(seq_m[2] + 2'd1));
        n_total++; if (st !== 3'd2 || sif.round_len !== 5'd3 || sif.cur_val !== seq_m[0]) $display("FAIL show_press_ignored: state %0d len %0d cur %0d, required 2/3/%0d", st, sif.round_len, sif.cur_val, seq_m[0]); else n_pass++;
        wait_input();
        press_pat(oh4(seq_m[0]));
        press_pat(oh4(seq_m[1] + 2'd1));
        n_total++; if (st !== 3'd6) $display("FAIL wrong_state: got %0d, required 6", st); else n_pass++;
        n_total++; if (sif.error_led !== 1'b1 || sif.win_led !== 1'b0) $display("FAIL wrong_leds: err %b win %b, required 1/0", sif.error_led, sif.win_led); else n_pass++;
        n_total++; if (sif.led !== 4'h0) $display("FAIL fail_led: got %h, required 0", sif.led); else n_pass++;
    endtask

    task automatic test_priority();
        logic [3:0] held;
        logic [1:0] e;
        bit found;
        start_game();
        n_total++; if (sif.error_led !== 1'b0) $display("FAIL err_clear: got %b, required 0", sif.error_led); else n_pass++;
        @(negedge clk);
        held = oh4(seq_m[0] + 2'd1);
        sif.btn = held;
        wait_input();
        repeat (5) @(negedge clk);
        #1;
        n_total++; if (st !== 3'd4 || sif.led !== held) $display("FAIL held_btn: state %0d led %h, required 4/%h", st, sif.led, held); else n_pass++;
        sif.btn = '0;
        repeat (4) @(negedge clk);
        #1;
        n_total++; if (st !== 3'd4 || sif.cur_val !== seq_m[0]) $display("FAIL held_release: state %0d cur %0d, required 4/%0d", st, sif.cur_val, seq_m[0]); else n_pass++;
        found = 1'b0;
        for (int r = 1; r <= ML && !found; r++) begin
            if (r > 1) wait_input();
            e = seq_m[r-1];
            for (int k = 0; k < r - 1; k++) press_pat(oh4(seq_m[k]));
            if (e == 2'd1 || e == 2'd2) begin
                found = 1'b1;
                press_pat(4'b0110);
                if (e == 2'd1) begin
                    n_total++; if (st !== ((r < ML) ? 3'd2 : 3'd5)) $display("FAIL prio_ok: got %0d, required %0d", st, (r < ML) ? 2 : 5); else n_pass++;
                end else begin
                    n_total++; if (st !== 3'd6 || sif.error_led !== 1'b1) $display("FAIL prio_wrong: state %0d err %b, required 6/1", st, sif.error_led); else n_pass++;
                end
            end else begin
                press_pat(oh4(e));
            end
        end
        n_total++; if (found !== 1'b1) $display("FAIL prio_found: got %b, required 1", found); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start_game();
        @(negedge clk);
        #1;
        n_total++; if (st !== 3'd2) $display("FAIL mid_pre: got %0d, required 2", st); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_total++; if (st !== 3'd0 || sif.led !== 4'h0 || sif.round_len !== 5'd0) $display("FAIL mid_reset: state %0d led %h len %0d, required 0/0/0", st, sif.led, sif.round_len); else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef SIMON_INPUT_TIMEOUT_EN
    task automatic test_timeout();
        int cnt, rel;
        bit pressed;
        start_game();
        tick_en = 1'b1;
        wait_state(3'd4, 200);
        cnt = 0;
        for (int i = 0; i < 400 && st != 3'd6; i++) begin
            if (st == 3'd4 && sif.tick) cnt++;
            @(negedge clk);
            #1;
        end
        n_total++; if (st !== 3'd6 || cnt !== 8) $display("FAIL timeout: state %0d ticks %0d, required 6/8", st, cnt); else n_pass++;
        start_game();
        wait_state(3'd4, 200);
        press_pat(oh4(seq_m[0]));
        wait_state(3'd4, 400);
        cnt = 0; rel = 0; pressed = 1'b0;
        for (int i = 0; i < 600 && st != 3'd6; i++) begin
            if (st == 3'd4 && sif.tick) cnt++;
            if (!pressed && cnt == 7) begin
                sif.btn = oh4(seq_m[0]);
                pressed = 1'b1;
                rel = 3;
            end else if (rel > 0) begin
                rel--;
                if (rel == 0) sif.btn = '0;
            end
            @(negedge clk);
            #1;
        end
        tick_en = 1'b0;
        n_total++; if (st !== 3'd6 || cnt !== 15) $display("FAIL timeout_restart: state %0d ticks %0d, required 6/15", st, cnt); else n_pass++;
    endtask
`else
    task automatic test_timeout();
        start_game();
        tick_en = 1'b1;
        wait_state(3'd4, 200);
        repeat (60) @(negedge clk);
        #1;
        tick_en = 1'b0;
        n_total++; if (st !== 3'd4 || sif.error_led !== 1'b0) $display("FAIL no_timeout: state %0d err %b, required 4/0", st, sif.error_led); else n_pass++;
    endtask
`endif

    initial begin
        sif.start = 1'b0;
        sif.btn   = '0;
        test_reset();
        test_first_round();
        test_win();
        test_fail();
        test_priority();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
